pc_sequencer: RTL and testbench

//  Fetch/execute sequencer that owns the program counter register's load port. It

---
 rtl/pc_seq_pkg.sv | 32 +++
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/ret_addr_stack.sv | 56 +++++
 rtl/pc_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch/execute sequencer.
//  state_e   : FSM state encoding (also driven out on the debug port)
//  pc_sel_e  : next-PC source chosen when the datapath signals exec_done
//  pick_sel  : resolves the ret > call > br_take > sequential priority
//              (halt_in is handled ahead of this in the FSM)
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_UPDATE = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_CALL = 2'd2,
        SEL_RET  = 2'd3
    } pc_sel_e;

    function automatic pc_sel_e pick_sel(input logic ret_i, input logic call_i,
                                         input logic br_i);
        pc_sel_e sel;
        if (ret_i)       sel = SEL_RET;
        else if (call_i) sel = SEL_CALL;
        else if (br_i)   sel = SEL_BR;
        else             sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus.
//  imem_req   : request, held high until imem_ack
//  imem_addr  : fetch address, valid while imem_req
//  imem_ack   : fetch complete, imem_data valid in the same cycle
//  imem_data  : fetched instruction
// Handshake: a transfer completes on a rising edge where imem_req and
// imem_ack are both high; imem_ack while imem_req is low has no effect.
interface pc_sequencer_if #(
    parameter int AW = 16,
    parameter int IW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack (LIFO) used for call/ret.
//  clk, reset : clock, synchronous active-high reset (pointer only)
//  push       : store push_data on top (ignored when full)
//  pop        : drop the top entry (ignored when empty)
//  push_data  : address to push
//  top        : current top entry (meaningless when empty)
//  full/empty : ptr == DEPTH / ptr == 0
// Entry storage is deliberately not reset; only the pointer is.
module ret_addr_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_PTR = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] IDX_ONE  = PW'(1);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW:0]   ptr_q, ptr_d;
    logic [PW-1:0] top_idx;

    assign full    = (ptr_q == FULL_PTR);
    assign empty   = (ptr_q == '0);
    assign top_idx = ptr_q[PW-1:0] - IDX_ONE;
    assign top     = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (push && !full)
            ptr_d = ptr_q + PTR_ONE;
        else if (pop && !empty)
            ptr_d = ptr_q - PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    // ptr_q low bits address the next free slot; full blocks the push so
    // the wrapped index at ptr==DEPTH is never written.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the program-counter load port.
//  clk, reset : clock, synchronous active-high reset
//  pc_in      : current pc register value
//  ld_pc      : next-PC value to the pc register
//  wr_pc      : pc register write strobe, one-cycle pulse in UPDATE
//  imem       : fetch bus (master side)
//  ir         : latched instruction; ir_valid high throughout EXEC
//  exec_done  : datapath finished; br_take/call/ret/br_target/halt_in sampled
//  halted     : in HALT (absorbing until reset)
//  stack_err  : sticky, return-stack overflow/underflow caused the halt
//  dbg_state  : current FSM state
// All outputs are registered. Loop: FETCH -> EXEC -> UPDATE -> FETCH.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int AW        = 16,
    parameter int IW        = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         pc_in,
    output logic [AW-1:0]         ld_pc,
    output logic                  wr_pc,
    pc_sequencer_if.master        imem,
    output logic [IW-1:0]         ir,
    output logic                  ir_valid,
    input  logic                  exec_done,
    input  logic                  br_take,
    input  logic                  call,
    input  logic                  ret,
    input  logic [AW-1:0]         br_target,
    input  logic                  halt_in,
    output logic                  halted,
    output logic                  stack_err,
    output state_e                dbg_state
);
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] ld_pc_q, ld_pc_d;
    logic          wr_pc_q, wr_pc_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          halted_q, halted_d;
    logic          stack_err_q, stack_err_d;

    pc_sel_e       sel;
    logic [AW-1:0] pc_inc;
    logic          ras_push, ras_pop, ras_full, ras_empty;
    logic [AW-1:0] ras_top;

    assign pc_inc = pc_in + PC_ONE;   // wraps at 2^AW
    assign sel    = pick_sel(ret, call, br_take);

    ret_addr_stack #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        state_d     = state_q;
        ld_pc_d     = ld_pc_q;
        wr_pc_d     = 1'b0;
        req_d       = req_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        halted_d    = halted_q;
        stack_err_d = stack_err_q;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    // First FETCH cycle after reset: raise the request.
                    req_d  = 1'b1;
                    addr_d = pc_in;
                end else if (imem.imem_ack) begin
                    req_d      = 1'b0;
                    ir_d       = imem.imem_data;
                    ir_valid_d = 1'b1;
                    state_d    = S_EXEC;
                end else begin
                    addr_d = pc_in;
                end
            end

            S_EXEC: begin
                if (exec_done) begin
                    ir_valid_d = 1'b0;
                    if (halt_in) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_UPDATE;
                        wr_pc_d = 1'b1;
                        case (sel)
                            SEL_RET: begin
                                if (ras_empty) begin
                                    state_d     = S_HALT;
                                    wr_pc_d     = 1'b0;
                                    halted_d    = 1'b1;
                                    stack_err_d = 1'b1;
                                end else begin
                                    ras_pop = 1'b1;
                                    ld_pc_d = ras_top;
                                end
                            end
                            SEL_CALL: begin
                                if (ras_full) begin
                                    state_d     = S_HALT;
                                    wr_pc_d     = 1'b0;
                                    halted_d    = 1'b1;
                                    stack_err_d = 1'b1;
                                end else begin
                                    ras_push = 1'b1;
                                    ld_pc_d  = br_target;
                                end
                            end
                            SEL_BR:  ld_pc_d = br_target;
                            default: ld_pc_d = pc_inc;
                        endcase
                    end
                end
            end

            S_UPDATE: begin
                // pc_in still holds the old value here; the register takes
                // ld_pc on this edge, so the next fetch address is ld_pc.
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = ld_pc_q;
            end

            default: begin
                // S_HALT: absorbing, all inputs ignored.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            ld_pc_q     <= '0;
            wr_pc_q     <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_pc_q     <= ld_pc_d;
            wr_pc_q     <= wr_pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign ld_pc          = ld_pc_q;
    assign wr_pc          = wr_pc_q;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign ir             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign halted         = halted_q;
    assign stack_err      = stack_err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the pc register and instruction memory,
// queues expected ld_pc values on exec_done and checks them on wr_pc.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int AW = 16;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] ld_pc;
    logic          wr_pc;
    logic [IW-1:0] ir;
    logic          ir_valid;
    logic          exec_done, br_take, call, ret, halt_in;
    logic [AW-1:0] br_target;
    logic          halted, stack_err;
    state_e        dbg_state;

    pc_sequencer_if #(.AW(AW), .IW(IW)) imem_bus ();

    pc_sequencer #(.AW(AW), .IW(IW), .RAS_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .ld_pc     (ld_pc),
        .wr_pc     (wr_pc),
        .imem      (imem_bus.master),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .exec_done (exec_done),
        .br_take   (br_take),
        .call      (call),
        .ret       (ret),
        .br_target (br_target),
        .halt_in   (halt_in),
        .halted    (halted),
        .stack_err (stack_err),
        .dbg_state (dbg_state)
    );

    // pc register model: preset by the bench, otherwise loaded by wr_pc
    logic          pc_load_en;
    logic [AW-1:0] pc_load_val;
    always @(posedge clk) begin
        if (pc_load_en)  pc_in <= pc_load_val;
        else if (wr_pc)  pc_in <= ld_pc;
    end

    int checks   = 0;
    int failures = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every wr_pc pulse consumes one expected next-PC
    always @(negedge clk) begin
        if (!reset && wr_pc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_pc", 32'(wr_pc), 32'd0);
            end else begin
                exp_val = exp_q.pop_front();
                chk("ld_pc", 32'(ld_pc), 32'(exp_val));
                chk("wr_state", 32'(dbg_state), 32'(S_UPDATE));
            end
        end
    end

    task automatic clear_ctrl();
        exec_done = 1'b0; br_take = 1'b0; call = 1'b0; ret = 1'b0;
        halt_in = 1'b0; br_target = '0;
    endtask

    task automatic do_reset(input logic [AW-1:0] pc);
        reset = 1'b1;
        pc_load_en = 1'b1;
        pc_load_val = pc;
        clear_ctrl();
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_data = '0;
        tick();
        pc_load_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Wait for a request, check its address, stall nwait cycles, then ack.
    task automatic fetch(input logic [AW-1:0] exp_addr, input logic [IW-1:0] data,
                         input int nwait);
        int n = 0;
        while (!imem_bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", 32'(imem_bus.imem_req), 32'd1);
        if (!imem_bus.imem_req) return;
        chk("fetch_addr", 32'(imem_bus.imem_addr), 32'(exp_addr));
        for (int i = 0; i < nwait; i++) begin
            // exec_done outside EXEC must be ignored
            exec_done = 1'b1;
            br_take = 1'(i);
            imem_bus.imem_data = 16'($urandom_range(0, 65535));
            tick();
            chk("req_held", 32'(imem_bus.imem_req), 32'd1);
            chk("no_ir_valid", 32'(ir_valid), 32'd0);
        end
        clear_ctrl();
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_data = data;
        tick();
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_data = 16'($urandom_range(0, 65535));
        chk("ir", 32'(ir), 32'(data));
        chk("ir_valid", 32'(ir_valid), 32'd1);
        chk("exec_state", 32'(dbg_state), 32'(S_EXEC));
        chk("req_drop", 32'(imem_bus.imem_req), 32'd0);
    endtask

    task automatic exec(input logic b, input logic c, input logic r, input logic h,
                        input logic [AW-1:0] tgt, input logic wr,
                        input logic [AW-1:0] exp_next, input logic exp_err);
        exec_done = 1'b1; br_take = b; call = c; ret = r; halt_in = h; br_target = tgt;
        if (wr) exp_q.push_back(exp_next);
        tick();
        clear_ctrl();
        if (wr) begin
            chk("wr_pc_pulse", 32'(wr_pc), 32'd1);
            chk("ir_valid_off", 32'(ir_valid), 32'd0);
            tick();
            chk("wr_pc_once", 32'(wr_pc), 32'd0);
            chk("refetch_req", 32'(imem_bus.imem_req), 32'd1);
            chk("refetch_addr", 32'(imem_bus.imem_addr), 32'(exp_next));
            chk("refetch_state", 32'(dbg_state), 32'(S_FETCH));
        end else begin
            chk("halted", 32'(halted), 32'd1);
            chk("stack_err", 32'(stack_err), 32'(exp_err));
            chk("halt_wr_pc", 32'(wr_pc), 32'd0);
            chk("halt_req", 32'(imem_bus.imem_req), 32'd0);
            chk("halt_state", 32'(dbg_state), 32'(S_HALT));
        end
    endtask

    // In HALT, hammer exec_done/ack and confirm nothing moves.
    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) begin
            exec_done = 1'b1;
            ret = 1'b1;
            imem_bus.imem_ack = 1'b1;
            imem_bus.imem_data = 16'($urandom_range(0, 65535));
            tick();
            chk("hold_halted", 32'(halted), 32'd1);
            chk("hold_req", 32'(imem_bus.imem_req), 32'd0);
            chk("hold_wr_pc", 32'(wr_pc), 32'd0);
            chk("hold_ir_valid", 32'(ir_valid), 32'd0);
        end
        clear_ctrl();
        imem_bus.imem_ack = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] cur;
        logic [AW-1:0] tgt;

        // Reset state
        do_reset(16'h0010);
        chk("rst_state", 32'(dbg_state), 32'(S_FETCH));
        chk("rst_ld_pc", 32'(ld_pc), 32'd0);
        chk("rst_wr_pc", 32'(wr_pc), 32'd0);
        chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst_addr", 32'(imem_bus.imem_addr), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stack_err", 32'(stack_err), 32'd0);
        tick();
        chk("req_after_rst", 32'(imem_bus.imem_req), 32'd1);

        // Sequential
        fetch(16'h0010, 16'hA001, 2);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0);
        fetch(16'h0011, 16'hA002, 0);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b0);

        // Wrap
        do_reset(16'hFFFF);
        fetch(16'hFFFF, 16'hB000, 1);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);

        // Priority: call beats br_take, ret beats call, then plain branch,
        // then ret on the emptied stack
        do_reset(16'h0040);
        fetch(16'h0040, 16'hC001, 0);
        exec(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 1'b1, 16'h0200, 1'b0);
        fetch(16'h0200, 16'hC002, 1);
        exec(1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 1'b1, 16'h0041, 1'b0);
        fetch(16'h0041, 16'hC003, 0);
        exec(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b0);
        fetch(16'h1234, 16'hC004, 0);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Overflow: four nested calls fit, the fifth halts
        do_reset(16'h0100);
        cur = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            tgt = 16'h1000 + 16'(i * 16'h0010);
            fetch(cur, 16'(16'hD000 + i), i % 2);
            exec(1'b0, 1'b1, 1'b0, 1'b0, tgt, 1'b1, tgt, 1'b0);
            cur = tgt;
        end
        fetch(cur, 16'hD0FF, 0);
        exec(1'b0, 1'b1, 1'b0, 1'b0, 16'h2000, 1'b0, 16'h0000, 1'b1);
        halt_hold(3);
        reset = 1'b1;
        tick();
        chk("rst_clears_err", 32'(stack_err), 32'd0);
        chk("rst_clears_halt", 32'(halted), 32'd0);

        // Underflow: ret on an empty stack right after reset
        do_reset(16'h0020);
        fetch(16'h0020, 16'hE001, 0);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Reset together with an ack mid-fetch
        do_reset(16'h0030);
        tick();
        chk("mid_req", 32'(imem_bus.imem_req), 32'd1);
        reset = 1'b1;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_data = 16'hBEEF;
        tick();
        reset = 1'b0;
        imem_bus.imem_ack = 1'b0;
        chk("mid_ir", 32'(ir), 32'd0);
        chk("mid_ir_valid", 32'(ir_valid), 32'd0);
        chk("mid_req_low", 32'(imem_bus.imem_req), 32'd0);
        chk("mid_state", 32'(dbg_state), 32'(S_FETCH));
        tick();
        chk("mid_req_again", 32'(imem_bus.imem_req), 32'd1);
        chk("mid_addr", 32'(imem_bus.imem_addr), 32'h0030);

        // Halt wins over ret (empty stack would otherwise set stack_err)
        do_reset(16'h0050);
        fetch(16'h0050, 16'hF001, 1);
        exec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        halt_hold(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_cleared", 32'(halted), 32'd0);
        chk("halt_clr_state", 32'(dbg_state), 32'(S_FETCH));
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "simulation time limit reached");
    end

endmodule
